// File: rtl/watch_set_ctrl_if.sv
// rtl/watch_set_ctrl_if.sv - button inputs and set-mode outputs of the watch control stage
interface watch_set_ctrl_if;
  logic       btn_mode;
  logic       btn_sel;
  logic       btn_up;
  logic       btn_down;
  logic       sw_setting;
  logic       sec_up;
  logic       sec_down;
  logic       min_up;
  logic       min_down;
  logic       hour_up;
  logic       hour_down;
  logic [1:0] o_field;

  modport master (
    output btn_mode, btn_sel, btn_up, btn_down,
    input  sw_setting, sec_up, sec_down, min_up, min_down, hour_up, hour_down, o_field
  );

  modport slave (
    input  btn_mode, btn_sel, btn_up, btn_down,
    output sw_setting, sec_up, sec_down, min_up, min_down, hour_up, hour_down, o_field
  );
endinterface

// File: rtl/watch_set_ctrl.sv
// rtl/watch_set_ctrl.sv - button sync/debounce, run/set FSM and field up/down strobes with auto-repeat
module watch_set_ctrl #(
  parameter int DB_CYCLES     = 1_000_000,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic             clk,
  input  logic             reset,
  watch_set_ctrl_if.slave  bus
);
  localparam int DBW = $clog2(DB_CYCLES) + 1;
  localparam int RDW = $clog2(REPEAT_DELAY) + 1;
  localparam int RPW = $clog2(REPEAT_PERIOD) + 1;

  typedef enum logic [1:0] {RUN = 2'd0, SET_SEC = 2'd1, SET_MIN = 2'd2, SET_HOUR = 2'd3} state_t;

  // Bit order of the button vectors: 0 mode, 1 sel, 2 up, 3 down
  logic [3:0]     w_raw;
  logic [3:0]     r_sync1, r_sync2, r_db, r_db_d, r_evt;
  logic [DBW-1:0] r_db_cnt [4];

  state_t         r_state, w_next;
  logic           r_sw;
  logic [5:0]     r_strobe, w_strobe;
  logic           r_rpt_on, r_rpt_first, r_rpt_dir;
  logic [RDW-1:0] r_dly_cnt;
  logic [RPW-1:0] r_per_cnt;
  logic           w_rpt_arm, w_rpt_clr, w_rpt_fire, w_rpt_dir, w_held;

  assign w_raw = {bus.btn_down, bus.btn_up, bus.btn_sel, bus.btn_mode};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_d  <= '0;
      r_evt   <= '0;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
          r_db[i]     <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
      r_db_d <= r_db;
      r_evt  <= r_db & ~r_db_d;
    end
  end

  function automatic logic [5:0] f_strobe(input state_t s, input logic dir);
    case (s)
      SET_SEC:  f_strobe = dir ? 6'b000010 : 6'b000001;
      SET_MIN:  f_strobe = dir ? 6'b001000 : 6'b000100;
      SET_HOUR: f_strobe = dir ? 6'b100000 : 6'b010000;
      default:  f_strobe = 6'b000000;
    endcase
  endfunction

  assign w_held = r_rpt_dir ? r_db[3] : r_db[2];

  // Priority chain: mode, then sel, then up/down, then the running auto-repeat
  always_comb begin
    w_next     = r_state;
    w_strobe   = '0;
    w_rpt_arm  = 1'b0;
    w_rpt_clr  = 1'b0;
    w_rpt_fire = 1'b0;
    w_rpt_dir  = r_rpt_dir;
    if (r_evt[0]) begin
      w_next    = (r_state == RUN) ? SET_SEC : RUN;
      w_rpt_clr = 1'b1;
    end else if (r_evt[1]) begin
      w_rpt_clr = 1'b1;
      case (r_state)
        SET_SEC:  w_next = SET_MIN;
        SET_MIN:  w_next = SET_HOUR;
        SET_HOUR: w_next = SET_SEC;
        default:  w_next = RUN;
      endcase
    end else if (r_evt[2] && r_evt[3]) begin
      w_rpt_clr = 1'b1;
    end else if ((r_evt[2] || r_evt[3]) && r_state != RUN) begin
      w_strobe  = f_strobe(r_state, r_evt[3]);
      w_rpt_arm = 1'b1;
      w_rpt_dir = r_evt[3];
    end else if (r_rpt_on) begin
      if (r_state == RUN || (r_db[2] && r_db[3]) || !w_held) begin
        w_rpt_clr = 1'b1;
      end else if (r_rpt_first ? (r_dly_cnt == RDW'(REPEAT_DELAY - 1))
                               : (r_per_cnt == RPW'(REPEAT_PERIOD - 1))) begin
        w_strobe   = f_strobe(r_state, r_rpt_dir);
        w_rpt_fire = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= RUN;
      r_sw        <= 1'b0;
      r_strobe    <= '0;
      r_rpt_on    <= 1'b0;
      r_rpt_first <= 1'b0;
      r_rpt_dir   <= 1'b0;
      r_dly_cnt   <= '0;
      r_per_cnt   <= '0;
    end else begin
      r_state  <= w_next;
      r_sw     <= (w_next != RUN);
      r_strobe <= w_strobe;
      if (w_rpt_clr) begin
        r_rpt_on <= 1'b0;
      end else if (w_rpt_arm) begin
        r_rpt_on    <= 1'b1;
        r_rpt_first <= 1'b1;
        r_rpt_dir   <= w_rpt_dir;
        r_dly_cnt   <= '0;
        r_per_cnt   <= '0;
      end else if (r_rpt_on) begin
        if (w_rpt_fire) begin
          r_rpt_first <= 1'b0;
          r_dly_cnt   <= '0;
          r_per_cnt   <= '0;
        end else if (r_rpt_first) begin
          r_dly_cnt <= r_dly_cnt + 1'b1;
        end else begin
          r_per_cnt <= r_per_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.sw_setting = r_sw;
  assign bus.o_field    = r_state;
  assign bus.sec_up     = r_strobe[0];
  assign bus.sec_down   = r_strobe[1];
  assign bus.min_up     = r_strobe[2];
  assign bus.min_down   = r_strobe[3];
  assign bus.hour_up    = r_strobe[4];
  assign bus.hour_down  = r_strobe[5];
endmodule

// File: tb/tb_watch_set_ctrl.sv
// tb/tb_watch_set_ctrl.sv - scoreboard bench for watch_set_ctrl with short debounce/repeat timings
module tb_watch_set_ctrl;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 5;
  localparam logic [5:0] SEC_UP  = 6'b000001;
  localparam logic [5:0] SEC_DN  = 6'b000010;
  localparam logic [5:0] MIN_UP  = 6'b000100;
  localparam logic [5:0] HOUR_DN = 6'b100000;

  typedef struct {
    logic [5:0] code;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_sw_rise = 0;
  logic [5:0] prev_w = '0;
  logic       sw_prev = 1'b0;
  exp_t exp_q[$];

  watch_set_ctrl_if u_if ();

  watch_set_ctrl #(
    .DB_CYCLES    (DB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] strobes();
    return {u_if.hour_down, u_if.hour_up, u_if.min_down, u_if.min_up, u_if.sec_down, u_if.sec_up};
  endfunction

  // Strobe monitor: every strobe must match the head of the scoreboard in code and cycle
  always @(negedge clk) begin
    logic [5:0] w;
    exp_t       e;
    w = strobes();
    if (w != 6'b0) begin
      chk("strobe_onehot", $countones(w), 1);
      if (prev_w != 6'b0) chk("strobe_width", prev_w, 0);
      if (exp_q.size() == 0) begin
        chk("strobe_unexpected", w, 0);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_code", w, e.code);
        chk("strobe_cyc", cyc, e.cyc);
      end
    end
    if (u_if.sw_setting && !sw_prev) n_sw_rise++;
    prev_w  = w;
    sw_prev = u_if.sw_setting;
  end

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       u_if.btn_mode = v;
      1:       u_if.btn_sel  = v;
      2:       u_if.btn_up   = v;
      default: u_if.btn_down = v;
    endcase
  endtask

  // Drive a clean press; the first strobe lands DB+4 cycles after the driving negedge
  task automatic press(input int b, input int hold, input logic [5:0] code, input int nstr);
    int   c0;
    exp_t e;
    @(negedge clk);
    c0 = cyc;
    set_btn(b, 1'b1);
    for (int k = 0; k < nstr; k++) begin
      e.code = code;
      e.cyc  = c0 + DB + 4 + ((k == 0) ? 0 : RD + (k - 1) * RP);
      exp_q.push_back(e);
    end
    repeat (hold) @(negedge clk);
    set_btn(b, 1'b0);
    repeat (DB + 8) @(negedge clk);
  endtask

  initial begin
    int   exp_f [5];
    int   c0;
    exp_t e;
    exp_f = '{2, 3, 1, 2, 3};
    u_if.btn_mode = 1'b0;
    u_if.btn_sel  = 1'b0;
    u_if.btn_up   = 1'b0;
    u_if.btn_down = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sw", u_if.sw_setting, 0);
    chk("rst_field", u_if.o_field, 0);
    chk("rst_strobes", strobes(), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 1: bouncing mode button settles into a single transition
    n_sw_rise = 0;
    for (int i = 0; i < 6; i++) begin
      u_if.btn_mode = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    press(0, DB + 8, 6'b0, 0);
    chk("bounce_transitions", n_sw_rise, 1);
    chk("bounce_sw", u_if.sw_setting, 1);
    chk("bounce_field", u_if.o_field, 1);

    // 2: sel cycles sec -> min -> hour -> sec; ignored in RUN
    for (int i = 0; i < 5; i++) begin
      press(1, DB + 8, 6'b0, 0);
      chk("sel_field", u_if.o_field, exp_f[i]);
    end
    press(0, DB + 8, 6'b0, 0);
    chk("run_field", u_if.o_field, 0);
    press(1, DB + 8, 6'b0, 0);
    chk("sel_in_run", u_if.o_field, 0);
    chk("sel_in_run_sw", u_if.sw_setting, 0);

    // 3: single up press in SET_MIN, then in RUN
    press(0, DB + 8, 6'b0, 0);
    press(1, DB + 8, 6'b0, 0);
    chk("min_field", u_if.o_field, 2);
    press(2, DB + 8, MIN_UP, 1);
    press(0, DB + 8, 6'b0, 0);
    press(2, DB + 8, 6'b0, 0);
    chk("up_in_run_field", u_if.o_field, 0);

    // 4: held down in SET_HOUR auto-repeats at 0,20,25..45
    press(0, DB + 8, 6'b0, 0);
    press(1, DB + 8, 6'b0, 0);
    press(1, DB + 8, 6'b0, 0);
    chk("hour_field", u_if.o_field, 3);
    press(3, 50, HOUR_DN, 7);
    repeat (30) @(negedge clk);
    chk("repeat_drained", exp_q.size(), 0);

    // 5: up+down together, then mode+up together from RUN
    @(negedge clk);
    u_if.btn_up   = 1'b1;
    u_if.btn_down = 1'b1;
    repeat (40) @(negedge clk);
    u_if.btn_up   = 1'b0;
    u_if.btn_down = 1'b0;
    repeat (DB + 8) @(negedge clk);
    chk("updown_field", u_if.o_field, 3);
    press(0, DB + 8, 6'b0, 0);
    @(negedge clk);
    u_if.btn_mode = 1'b1;
    u_if.btn_up   = 1'b1;
    repeat (DB + 8) @(negedge clk);
    u_if.btn_mode = 1'b0;
    u_if.btn_up   = 1'b0;
    repeat (DB + 8) @(negedge clk);
    chk("mode_up_field", u_if.o_field, 1);
    chk("mode_up_sw", u_if.sw_setting, 1);

    // 6: reset at offset 22 of a repeat sequence
    @(negedge clk);
    c0 = cyc;
    u_if.btn_down = 1'b1;
    e.code = SEC_DN;
    e.cyc  = c0 + DB + 4;
    exp_q.push_back(e);
    e.cyc  = c0 + DB + 4 + RD;
    exp_q.push_back(e);
    repeat (DB + 4 + 22) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_strobes", strobes(), 0);
    chk("async_rst_sw", u_if.sw_setting, 0);
    chk("async_rst_field", u_if.o_field, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (DB + 10) @(negedge clk);
    chk("post_rst_field", u_if.o_field, 0);
    chk("post_rst_sw", u_if.sw_setting, 0);
    u_if.btn_down = 1'b0;
    repeat (DB + 8) @(negedge clk);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
